// File: rtl/shared_resource_arb_n_pkg.sv
// Shared defaults and width helpers for the N-channel shared-resource arbiter.
package shared_res_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;

  // Smallest r such that 2**r >= v.
  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_resource_arb_n_if.sv
// Per-channel upstream/downstream bundle of the shared-resource arbiter.
interface shared_resource_arb_n_if
  import shared_res_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_flush;
  logic [N_CH-1:0]        in_stall;
  logic [N_CH-1:0]        out_stall;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_flush;
  logic [N_CH*DATA_W-1:0] out_data;

  modport master (
    output in_data, in_valid, in_flush, in_stall,
    input  out_stall, out_valid, out_flush, out_data
  );

  modport slave (
    input  in_data, in_valid, in_flush, in_stall,
    output out_stall, out_valid, out_flush, out_data
  );

endinterface

// File: rtl/shared_resource_arb_n_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter
  import shared_res_pkg::*;
#(
  parameter int N = N_CH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IDX_W = (N > 1) ? ceil_log2(N) : 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(last_q) + 1 + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        last_d     = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer holds when nobody asks; reset makes channel 0 the first winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= IDX_W'(N - 1);
    end else if (found) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shared_resource_arb_n.sv
// N client channels, each with a small FIFO, time-sharing one combinational
// resource through a round-robin arbiter; one registered result per channel.
module shared_resource_arb_n
  import shared_res_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic                    clk,
  input logic                    reset,
  shared_resource_arb_n_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? ceil_log2(DEPTH) : 1;
  localparam int CNT_W = ceil_log2(DEPTH + 1);

  function automatic logic [DATA_W-1:0] shared_resource(input logic [DATA_W-1:0] x);
    return {x[DATA_W-2:0], x[DATA_W-1]} ^ x;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   empty;
  logic [N_CH-1:0]   full;
  logic [N_CH-1:0]   ready;
  logic [N_CH-1:0]   enq;
  logic [N_CH-1:0]   deq;
  logic [DATA_W-1:0] head_p0 [N_CH];
  logic [DATA_W-1:0] res_in_p0;
  logic [DATA_W-1:0] res_out_p0;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  // ---- stage p0: granted head through the single shared resource ----
  always_comb begin
    res_in_p0 = '0;
    for (int k = 0; k < N_CH; k++) begin
      res_in_p0 = res_in_p0 | (head_p0[k] & {DATA_W{grant[k]}});
    end
  end

  assign res_out_p0 = shared_resource(res_in_p0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] din_p0;
    logic              vld_p1;
    logic              flush_p1;
    logic [DATA_W-1:0] data_p1;

    assign din_p0     = bus.in_data[i*DATA_W +: DATA_W];
    assign empty[i]   = (count == '0);
    assign full[i]    = (count == CNT_W'(DEPTH));
    assign head_p0[i] = empty[i] ? din_p0 : mem[rd_ptr];

    // A held, stalled result blocks the channel from being granted again.
    assign ready[i] = !(bus.in_stall[i] & vld_p1);
    assign req[i]   = (bus.in_valid[i] | !empty[i]) & ready[i] & !bus.in_flush[i];
    assign enq[i]   = bus.in_valid[i] & !full[i] & !(grant[i] & empty[i]) & !bus.in_flush[i];
    assign deq[i]   = grant[i] & !empty[i];

    always_ff @(posedge clk) begin
      if (enq[i]) begin
        mem[wr_ptr] <= din_p0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (bus.in_flush[i]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq[i]) wr_ptr <= next_ptr(wr_ptr);
        if (deq[i]) rd_ptr <= next_ptr(rd_ptr);
        if (enq[i] && !deq[i]) begin
          count <= count + 1'b1;
        end else if (!enq[i] && deq[i]) begin
          count <= count - 1'b1;
        end
      end
    end

    // ---- stage p1: registered per-channel result ----
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p1   <= 1'b0;
        flush_p1 <= 1'b0;
        data_p1  <= '0;
      end else begin
        flush_p1 <= bus.in_flush[i];
        if (bus.in_flush[i]) begin
          vld_p1 <= 1'b0;
        end else if (grant[i]) begin
          vld_p1  <= 1'b1;
          data_p1 <= res_out_p0;
        end else if (!(bus.in_stall[i] & vld_p1)) begin
          vld_p1 <= 1'b0;
        end
      end
    end

    assign bus.out_stall[i]                   = full[i];
    assign bus.out_valid[i]                   = vld_p1;
    assign bus.out_flush[i]                   = flush_p1;
    assign bus.out_data[i*DATA_W +: DATA_W]   = data_p1;
  end

endmodule

// File: tb/tb_shared_resource_arb_n.sv
// Directed bench for shared_resource_arb_n (4 channels, 32-bit, depth 2).
module tb_shared_resource_arb_n;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   viol    = 0;

  shared_resource_arb_n_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  shared_resource_arb_n #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Upstream protocol monitor: data offered while the channel signals backpressure.
  always @(negedge clk) begin
    if (!reset) viol = viol + $countones(bus.in_valid & bus.out_stall);
  end

  function automatic logic [31:0] res(input logic [31:0] x);
    return ((x << 1) | (x >> 31)) ^ x;
  endfunction

  function automatic logic [31:0] get_out(input int ch);
    return bus.out_data[ch*DATA_W +: DATA_W];
  endfunction

  task automatic set_data(input int ch, input logic [31:0] v);
    bus.in_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_data  = '0;
    bus.in_valid = '0;
    bus.in_flush = '0;
    bus.in_stall = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid got %h want %h", bus.out_valid, 4'h0); end
    n_tests++; if (bus.out_flush !== 4'h0) begin n_fail++; $display("FAIL reset_out_flush got %h want %h", bus.out_flush, 4'h0); end
    n_tests++; if (bus.out_stall !== 4'h0) begin n_fail++; $display("FAIL reset_out_stall got %h want %h", bus.out_stall, 4'h0); end
    n_tests++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
  endtask

  task automatic test_bypass();
    do_reset();
    bus.in_valid = 4'b0100;
    set_data(2, 32'h5);
    step();
    n_tests++; if (bus.out_valid !== 4'b0100) begin n_fail++; $display("FAIL bypass_valid got %h want %h", bus.out_valid, 4'b0100); end
    n_tests++; if (get_out(2) !== 32'hF) begin n_fail++; $display("FAIL bypass_data got %h want %h", get_out(2), 32'hF); end
    n_tests++; if (bus.out_stall !== 4'h0) begin n_fail++; $display("FAIL bypass_stall got %h want %h", bus.out_stall, 4'h0); end
    bus.in_valid = 4'b0000;
    step();
    n_tests++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL bypass_drop got %h want %h", bus.out_valid, 4'h0); end
    n_tests++; if (get_out(2) !== res(32'h5)) begin n_fail++; $display("FAIL bypass_hold got %h want %h", get_out(2), res(32'h5)); end
    step();
    n_tests++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL bypass_no_fifo_entry got %h want %h", bus.out_valid, 4'h0); end
  endtask

  task automatic test_all_valid();
    logic [3:0] exp_vld [5];
    logic [3:0] exp_stl [5];
    int v0;
    exp_vld = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    exp_stl = '{4'h0, 4'hC, 4'hB, 4'h7, 4'hE};
    do_reset();
    v0 = viol;
    for (int i = 0; i < N_CH; i++) set_data(i, 32'h100 + i);
    bus.in_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++; if (bus.out_valid !== exp_vld[c]) begin n_fail++; $display("FAIL allvalid_grant[%0d] got %h want %h", c, bus.out_valid, exp_vld[c]); end
      n_tests++; if (bus.out_stall !== exp_stl[c]) begin n_fail++; $display("FAIL allvalid_stall[%0d] got %h want %h", c, bus.out_stall, exp_stl[c]); end
    end
    for (int i = 0; i < N_CH; i++) begin
      n_tests++; if (get_out(i) !== res(32'h100 + i)) begin n_fail++; $display("FAIL allvalid_data[%0d] got %h want %h", i, get_out(i), res(32'h100 + i)); end
    end
    bus.in_valid = 4'h0;
    $display("[TB] all-valid scenario: %0d protocol violations flagged (in_valid while out_stall)", viol - v0);
  endtask

  task automatic test_stall();
    logic [3:0] exp_vld [3];
    exp_vld = '{4'b0110, 4'b0011, 4'b0110};
    do_reset();
    bus.in_valid = 4'b0010;
    set_data(1, 32'h11);
    step();
    n_tests++; if (bus.out_valid !== 4'b0010) begin n_fail++; $display("FAIL stall_first got %h want %h", bus.out_valid, 4'b0010); end
    bus.in_valid = 4'b0101;
    bus.in_stall = 4'b0010;
    set_data(0, 32'h30);
    set_data(2, 32'h32);
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (bus.out_valid !== exp_vld[c]) begin n_fail++; $display("FAIL stall_valid[%0d] got %h want %h", c, bus.out_valid, exp_vld[c]); end
      n_tests++; if (get_out(1) !== 32'h33) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", c, get_out(1), 32'h33); end
      if (c == 0) begin
        n_tests++; if (get_out(2) !== res(32'h32)) begin n_fail++; $display("FAIL stall_other_data got %h want %h", get_out(2), res(32'h32)); end
      end
    end
    bus.in_valid = 4'b0000;
    bus.in_stall = 4'b0000;
    step();
    n_tests++; if (bus.out_valid !== 4'b0001) begin n_fail++; $display("FAIL stall_release got %h want %h", bus.out_valid, 4'b0001); end
    n_tests++; if (get_out(0) !== res(32'h30)) begin n_fail++; $display("FAIL stall_ch0_data got %h want %h", get_out(0), res(32'h30)); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.in_valid = 4'b1001;
    set_data(0, 32'hA0);
    set_data(3, 32'hD3);
    step();
    bus.in_valid = 4'b0001;
    bus.in_stall = 4'b0001;
    set_data(0, 32'hA1);
    step();
    n_tests++; if (get_out(3) !== res(32'hD3)) begin n_fail++; $display("FAIL flush_ch3_data got %h want %h", get_out(3), res(32'hD3)); end
    set_data(0, 32'hA2);
    bus.in_stall = 4'b1001;
    step();
    n_tests++; if (bus.out_stall !== 4'b0001) begin n_fail++; $display("FAIL flush_prefill_stall got %h want %h", bus.out_stall, 4'b0001); end
    n_tests++; if (bus.out_valid !== 4'b1001) begin n_fail++; $display("FAIL flush_prefill_valid got %h want %h", bus.out_valid, 4'b1001); end
    bus.in_valid = 4'b0000;
    bus.in_flush = 4'b0001;
    step();
    n_tests++; if (bus.out_flush !== 4'b0001) begin n_fail++; $display("FAIL flush_out_flush got %h want %h", bus.out_flush, 4'b0001); end
    n_tests++; if (bus.out_valid !== 4'b1000) begin n_fail++; $display("FAIL flush_out_valid got %h want %h", bus.out_valid, 4'b1000); end
    n_tests++; if (bus.out_stall !== 4'b0000) begin n_fail++; $display("FAIL flush_out_stall got %h want %h", bus.out_stall, 4'b0000); end
    n_tests++; if (get_out(3) !== res(32'hD3)) begin n_fail++; $display("FAIL flush_ch3_undisturbed got %h want %h", get_out(3), res(32'hD3)); end
    bus.in_flush = 4'b0000;
    bus.in_stall = 4'b1000;
    step();
    n_tests++; if (bus.out_flush !== 4'b0000) begin n_fail++; $display("FAIL flush_clears got %h want %h", bus.out_flush, 4'b0000); end
    n_tests++; if (bus.out_valid !== 4'b1000) begin n_fail++; $display("FAIL flush_fifo_empty got %h want %h", bus.out_valid, 4'b1000); end
    bus.in_stall = 4'b0000;
    step();
    n_tests++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_idle got %h want %h", bus.out_valid, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_seq [3];
    int k;
    int v0;
    exp_seq = '{res(32'h0A), res(32'h0B), res(32'h0C)};
    do_reset();
    v0 = viol;
    k  = 0;
    set_data(1, 32'h111);
    set_data(2, 32'h222);
    for (int c = 0; c < 20; c++) begin
      if (c == 0) begin bus.in_valid = 4'b0111; set_data(0, 32'h0A); end
      if (c == 1) begin bus.in_valid = 4'b0111; set_data(0, 32'h0B); end
      if (c == 2) begin bus.in_valid = 4'b0001; set_data(0, 32'h0C); end
      if (c == 3) bus.in_valid = 4'b0000;
      step();
      if (bus.out_valid[0]) begin
        if (k < 3) begin
          n_tests++; if (get_out(0) !== exp_seq[k]) begin n_fail++; $display("FAIL order_data[%0d] got %h want %h", k, get_out(0), exp_seq[k]); end
        end
        k++;
      end
    end
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL order_count got %0d want %0d", k, 3); end
    n_tests++; if (viol !== v0) begin n_fail++; $display("FAIL order_protocol got %0d want %0d", viol - v0, 0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N_CH; i++) set_data(i, 32'h40 + i);
    bus.in_stall = 4'hF;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = ~bus.out_stall;
      step();
    end
    bus.in_valid = 4'h0;
    n_tests++; if (bus.out_stall !== 4'hF) begin n_fail++; $display("FAIL rstmid_all_full got %h want %h", bus.out_stall, 4'hF); end
    n_tests++; if (bus.out_valid !== 4'hF) begin n_fail++; $display("FAIL rstmid_all_valid got %h want %h", bus.out_valid, 4'hF); end
    reset = 1'b1;
    #1;
    n_tests++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL rstmid_valid got %h want %h", bus.out_valid, 4'h0); end
    n_tests++; if (bus.out_stall !== 4'h0) begin n_fail++; $display("FAIL rstmid_stall got %h want %h", bus.out_stall, 4'h0); end
    n_tests++; if (bus.out_flush !== 4'h0) begin n_fail++; $display("FAIL rstmid_flush got %h want %h", bus.out_flush, 4'h0); end
    n_tests++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", bus.out_data); end
    step();
    reset = 1'b0;
    bus.in_stall = 4'h0;
    bus.in_valid = 4'hF;
    step();
    bus.in_valid = 4'h0;
    n_tests++; if (bus.out_valid !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant got %h want %h", bus.out_valid, 4'b0001); end
    n_tests++; if (get_out(0) !== res(32'h40)) begin n_fail++; $display("FAIL rstmid_first_data got %h want %h", get_out(0), res(32'h40)); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_bypass();
    test_all_valid();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
